// File: rtl/i2s_master_tx.sv
// I2S bus master: generates SCK/WS and serialises one buffered L/R pair per 2*SLOT_BITS-bit frame.
// Outputs are registered; the single-entry input buffer stalls o_ready until the pair is loaded at frame edge k=0.
module i2s_master_tx #(
  parameter int CLK_DIV   = 4,
  parameter int SLOT_BITS = 32,
  parameter int DATA_W    = 24
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_en,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_dataL,
  input  logic [DATA_W-1:0] i_dataR,
  output logic              o_sck,
  output logic              o_ws,
  output logic              o_sd,
  output logic              o_frameStart,
  output logic              o_underrun
);

  localparam int KW    = $clog2(2 * SLOT_BITS);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [KW-1:0]    K_LAST   = KW'(2 * SLOT_BITS - 1);
  localparam logic [KW-1:0]    K_WS_ON  = KW'(SLOT_BITS - 1);
  localparam logic [KW-1:0]    K_WS_OFF = KW'(2 * SLOT_BITS - 2);
  localparam logic [KW-1:0]    K_L_END  = KW'(DATA_W - 1);
  localparam logic [KW-1:0]    K_R_BEG  = KW'(SLOT_BITS);
  localparam logic [KW-1:0]    K_R_END  = KW'(SLOT_BITS + DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_STOP} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [KW-1:0]     r_k;
  logic              r_sck;
  logic              r_ws;
  logic              r_sd;
  logic              r_frame_start;
  logic              r_underrun;
  logic              r_ready;
  pair_t             r_buf;
  logic [DATA_W-1:0] r_sh_l;
  logic [DATA_W-1:0] r_sh_r;

  logic w_active;
  logic w_stop_now;
  logic w_fall;
  logic w_load;
  logic w_drive;

  // A stop requested before the first SCK rise has no frame to finish, so it exits at once.
  assign w_active   = (r_state == S_RUN) || (r_state == S_STOP);
  assign w_stop_now = (r_state == S_STOP) && (r_k == '0) && !r_sck;
  assign w_fall     = w_active && !w_stop_now && (r_div == DIV_LAST) && r_sck;
  assign w_load     = w_fall && (r_state == S_RUN) && (r_k == '0);
  assign w_drive    = w_fall && !((r_state == S_STOP) && (r_k == '0));

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_en) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (!i_en) begin
          w_state_nxt = S_IDLE;
        end else if (!r_ready) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN:  if (!i_en) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_stop_now || (w_fall && ((r_k == '0) || (r_k == K_LAST)))) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_div         <= '0;
      r_k           <= '0;
      r_sck         <= 1'b0;
      r_ws          <= 1'b0;
      r_sd          <= 1'b0;
      r_sh_l        <= '0;
      r_sh_r        <= '0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      if (!w_active || w_stop_now) begin
        r_div <= '0;
        r_k   <= '0;
        r_sck <= 1'b0;
        r_ws  <= 1'b0;
        r_sd  <= 1'b0;
      end else if (r_div == DIV_LAST) begin
        r_div <= '0;
        r_sck <= ~r_sck;
        if (w_drive) begin
          r_k  <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
          r_ws <= (r_k >= K_WS_ON) && (r_k <= K_WS_OFF);
          if (r_k == '0) begin
            r_frame_start <= 1'b1;
            if (!r_ready) begin
              r_sd   <= r_buf.l[DATA_W-1];
              r_sh_l <= {r_buf.l[DATA_W-2:0], 1'b0};
              r_sh_r <= r_buf.r;
            end else begin
              r_sd       <= 1'b0;
              r_sh_l     <= '0;
              r_sh_r     <= '0;
              r_underrun <= 1'b1;
            end
          end else if (r_k <= K_L_END) begin
            r_sd   <= r_sh_l[DATA_W-1];
            r_sh_l <= {r_sh_l[DATA_W-2:0], 1'b0};
          end else if ((r_k >= K_R_BEG) && (r_k <= K_R_END)) begin
            r_sd   <= r_sh_r[DATA_W-1];
            r_sh_r <= {r_sh_r[DATA_W-2:0], 1'b0};
          end else begin
            r_sd <= 1'b0;
          end
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  // o_ready is the inverted full flag; a write coinciding with a load is blocked, so no bypass path exists.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_ready <= 1'b1;
      r_buf   <= '0;
    end else if (w_load && !r_ready) begin
      r_ready <= 1'b1;
    end else if (i_valid && r_ready) begin
      r_buf   <= {i_dataL, i_dataR};
      r_ready <= 1'b0;
    end
  end

  assign o_ready      = r_ready;
  assign o_sck        = r_sck;
  assign o_ws         = r_ws;
  assign o_sd         = r_sd;
  assign o_frameStart = r_frame_start;
  assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Scoreboard bench for i2s_master_tx: accepted pairs are queued and compared against each decoded frame.
module tb_i2s_master_tx;

  logic        i_clk;
  logic        i_arst_n;
  logic        i_en;
  logic        i_valid;
  logic        o_ready;
  logic [23:0] i_dataL;
  logic [23:0] i_dataR;
  logic        o_sck;
  logic        o_ws;
  logic        o_sd;
  logic        o_frameStart;
  logic        o_underrun;

  i2s_master_tx #(.CLK_DIV(4), .SLOT_BITS(32), .DATA_W(24)) dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_en(i_en), .i_valid(i_valid), .o_ready(o_ready),
    .i_dataL(i_dataL), .i_dataR(i_dataR), .o_sck(o_sck), .o_ws(o_ws), .o_sd(o_sd),
    .o_frameStart(o_frameStart), .o_underrun(o_underrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    int          acc;
  } ent_t;

  ent_t        sb[$];
  logic [47:0] feed[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fs_cnt = 0;
  int ur_cnt = 0;
  int last_fs = 0;
  int fs_period = 0;
  bit ur_dbl = 0;
  bit prev_ur = 0;

  function automatic logic [63:0] exp_sd(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 24; k++) begin
      v[k]      = l[23-k];
      v[32 + k] = r[23-k];
    end
    return v;
  endfunction

  function automatic logic [63:0] exp_ws();
    logic [63:0] v;
    v = '0;
    for (int k = 31; k <= 62; k++) v[k] = 1'b1;
    return v;
  endfunction

  // One clock: record handshakes into the scoreboard, keep i_valid fed, track pulses.
  task automatic tick();
    bit   xfer;
    ent_t e;
    xfer = i_valid && o_ready && i_arst_n;
    @(posedge i_clk);
    #1;
    cyc++;
    if (xfer) begin
      e.l = i_dataL; e.r = i_dataR; e.acc = cyc;
      sb.push_back(e);
      i_valid = 1'b0;
    end
    if (!i_valid && feed.size() > 0 && i_arst_n) begin
      {i_dataL, i_dataR} = feed.pop_front();
      i_valid = 1'b1;
    end
    if (o_frameStart) begin
      fs_cnt++;
      fs_period = cyc - last_fs;
      last_fs = cyc;
    end
    if (o_underrun) begin
      ur_cnt++;
      if (prev_ur) ur_dbl = 1'b1;
    end
    prev_ur = o_underrun;
  endtask

  task automatic wait_fs(output int n, output bit ok);
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_frameStart && n < 2000);
    ok = o_frameStart;
  endtask

  // Pair the frame starting at fs_cyc with the oldest pair accepted strictly before it.
  task automatic pop_expect(input int fs_cyc, output logic [23:0] l, output logic [23:0] r, output bit uf);
    ent_t e;
    if (sb.size() > 0 && sb[0].acc < fs_cyc) begin
      e = sb.pop_front();
      l = e.l; r = e.r; uf = 1'b0;
    end else begin
      l = '0; r = '0; uf = 1'b1;
    end
  endtask

  task automatic capture(input int last_k, input int en_off_k,
                         output logic [63:0] sd, output logic [63:0] ws, output bit ok);
    bit prev;
    int guard;
    sd = '0; ws = '0; ok = 1'b1;
    sd[0] = o_sd; ws[0] = o_ws;
    for (int k = 1; k <= last_k; k++) begin
      guard = 0;
      do begin
        prev = o_sck;
        tick();
        guard++;
      end while (!(prev && !o_sck) && guard < 40);
      if (!(prev && !o_sck)) begin
        ok = 1'b0;
        break;
      end
      sd[k] = o_sd; ws[k] = o_ws;
      if (k == en_off_k) i_en = 1'b0;
    end
  endtask

  logic [23:0] el, er;
  bit          uf, ok;
  int          n;
  logic [63:0] sd_bits, ws_bits;

  task automatic test_reset();
    bit seen;
    #12;
    checks++;
    if ({o_sck, o_ws, o_sd, o_frameStart, o_underrun, o_ready} !== 6'b000001) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000001", {o_sck, o_ws, o_sd, o_frameStart, o_underrun, o_ready});
    end
    i_arst_n = 1'b1;
    tick();
    i_en = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (o_sck || o_frameStart || o_underrun) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL wait_no_sck got=%b exp=0", seen);
    end
  endtask

  task automatic test_first_frame();
    i_en = 1'b0;
    repeat (3) tick();
    feed.push_back({24'hA5A5A5, 24'h5A5A5A});
    n = 0;
    while (sb.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (o_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_when_full got=%b exp=0", o_ready);
    end
    i_en = 1'b1;
    wait_fs(n, ok);
    checks++;
    if (!ok || n !== 10) begin
      failures++;
      $display("FAIL first_fall_latency got=%0d exp=10", n);
    end
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_load got=%b exp=1", o_ready);
    end
    pop_expect(cyc, el, er, uf);
    checks++;
    if (o_underrun !== uf) begin
      failures++;
      $display("FAIL first_underrun got=%b exp=%b", o_underrun, uf);
    end
    capture(63, -1, sd_bits, ws_bits, ok);
    checks++;
    if (!ok || sd_bits !== exp_sd(el, er)) begin
      failures++;
      $display("FAIL first_sd got=%h exp=%h", sd_bits, exp_sd(el, er));
    end
    checks++;
    if (!ok || ws_bits !== exp_ws()) begin
      failures++;
      $display("FAIL first_ws got=%h exp=%h", ws_bits, exp_ws());
    end
  endtask

  task automatic test_underrun();
    int ur0;
    ur0 = ur_cnt;
    ur_dbl = 1'b0;
    wait_fs(n, ok);
    pop_expect(cyc, el, er, uf);
    checks++;
    if (!ok || o_underrun !== uf || uf !== 1'b1) begin
      failures++;
      $display("FAIL underrun_pulse got=%b exp=1", o_underrun);
    end
    checks++;
    if (fs_period !== 512) begin
      failures++;
      $display("FAIL frame_period got=%0d exp=512", fs_period);
    end
    capture(63, -1, sd_bits, ws_bits, ok);
    checks++;
    if (!ok || sd_bits !== exp_sd(el, er) || ws_bits !== exp_ws()) begin
      failures++;
      $display("FAIL underrun_frame sd=%h ws=%h exp_sd=%h exp_ws=%h", sd_bits, ws_bits, exp_sd(el, er), exp_ws());
    end
    checks++;
    if (ur_cnt - ur0 !== 1 || ur_dbl) begin
      failures++;
      $display("FAIL underrun_single got=%0d dbl=%b exp=1", ur_cnt - ur0, ur_dbl);
    end
  endtask

  task automatic test_back_to_back();
    int ur0;
    logic [23:0] l, r;
    ur0 = ur_cnt;
    for (int i = 0; i < 4; i++) begin
      l = 24'h000001 << i;
      r = 24'h800000 >> i;
      feed.push_back({l, r});
    end
    for (int i = 0; i < 4; i++) begin
      wait_fs(n, ok);
      pop_expect(cyc, el, er, uf);
      checks++;
      if (!ok || uf || o_underrun !== 1'b0) begin
        failures++;
        $display("FAIL stream_load%0d underrun=%b model_empty=%b", i, o_underrun, uf);
      end
      capture(63, -1, sd_bits, ws_bits, ok);
      checks++;
      if (!ok || sd_bits !== exp_sd(el, er) || ws_bits !== exp_ws()) begin
        failures++;
        $display("FAIL stream_frame%0d sd=%h exp=%h", i, sd_bits, exp_sd(el, er));
      end
      if (i < 3) begin
        checks++;
        if (o_ready !== 1'b0) begin
          failures++;
          $display("FAIL stream_ready%0d got=%b exp=0", i, o_ready);
        end
      end
    end
    checks++;
    if (ur_cnt !== ur0) begin
      failures++;
      $display("FAIL stream_underruns got=%0d exp=0", ur_cnt - ur0);
    end
  endtask

  task automatic test_stop();
    int fs0;
    bit seen;
    feed.push_back({24'h123456, 24'hFEDCBA});
    wait_fs(n, ok);
    pop_expect(cyc, el, er, uf);
    checks++;
    if (!ok || uf || o_underrun !== 1'b0) begin
      failures++;
      $display("FAIL stop_load underrun=%b model_empty=%b", o_underrun, uf);
    end
    feed.push_back({24'h0F0F0F, 24'hC3C3C3});
    capture(63, 10, sd_bits, ws_bits, ok);
    checks++;
    if (!ok || sd_bits !== exp_sd(el, er) || ws_bits !== exp_ws()) begin
      failures++;
      $display("FAIL stop_frame sd=%h exp=%h", sd_bits, exp_sd(el, er));
    end
    fs0 = fs_cnt;
    seen = 1'b0;
    repeat (600) begin
      tick();
      if (o_sck || o_ws) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || fs_cnt !== fs0) begin
      failures++;
      $display("FAIL stop_idle sck_or_ws=%b frames=%0d exp=0", seen, fs_cnt - fs0);
    end
    checks++;
    if (o_ready !== 1'b0 || sb.size() !== 1) begin
      failures++;
      $display("FAIL stop_retained ready=%b queued=%0d exp ready=0 queued=1", o_ready, sb.size());
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] m;
    bit seen;
    i_en = 1'b1;
    wait_fs(n, ok);
    checks++;
    if (!ok || n !== 10) begin
      failures++;
      $display("FAIL restart_latency got=%0d exp=10", n);
    end
    pop_expect(cyc, el, er, uf);
    capture(40, -1, sd_bits, ws_bits, ok);
    m = '0;
    for (int k = 0; k <= 40; k++) m[k] = 1'b1;
    checks++;
    if (!ok || (sd_bits & m) !== (exp_sd(el, er) & m)) begin
      failures++;
      $display("FAIL retained_pair sd=%h exp=%h", sd_bits & m, exp_sd(el, er) & m);
    end
    repeat (4) tick();
    checks++;
    if ({o_sck, o_ws} !== 2'b11) begin
      failures++;
      $display("FAIL pre_reset sck_ws=%b exp=11", {o_sck, o_ws});
    end
    #2;
    i_arst_n = 1'b0;
    #1;
    checks++;
    if ({o_sck, o_ws, o_sd, o_frameStart, o_underrun, o_ready} !== 6'b000001) begin
      failures++;
      $display("FAIL async_reset got=%b exp=000001", {o_sck, o_ws, o_sd, o_frameStart, o_underrun, o_ready});
    end
    sb.delete();
    feed.delete();
    i_valid = 1'b0;
    i_en = 1'b0;
    #2;
    i_arst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (o_sck || !o_ready) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got=%b exp=0", seen);
    end
    feed.push_back({24'h3C3C3C, 24'h999999});
    repeat (3) tick();
    i_en = 1'b1;
    wait_fs(n, ok);
    checks++;
    if (!ok || n !== 10) begin
      failures++;
      $display("FAIL post_reset_start got=%0d exp=10", n);
    end
    pop_expect(cyc, el, er, uf);
    capture(63, -1, sd_bits, ws_bits, ok);
    checks++;
    if (!ok || uf || sd_bits !== exp_sd(el, er)) begin
      failures++;
      $display("FAIL post_reset_frame sd=%h exp=%h", sd_bits, exp_sd(el, er));
    end
  endtask

  initial begin
    i_arst_n = 1'b0;
    i_en     = 1'b0;
    i_valid  = 1'b0;
    i_dataL  = '0;
    i_dataR  = '0;
    test_reset();
    test_first_frame();
    test_underrun();
    test_back_to_back();
    test_stop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
